// File: rtl/led_stream_rx.sv
// Receiver for the clocked serial LED stream: resynchronises sclk/sdat, deserialises
// MSB-first frames, and ends each frame on an idle gap with a bit-count check.
module led_stream_rx #(
  parameter int LEDS        = 50,
  parameter int IDLE_CYCLES = 3125
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk_in,
  input  logic                 sdat_in,
  output logic [24*LEDS-1:0]   led_rgb,
  output logic                 frame_valid,
  output logic                 frame_error,
  output logic                 busy,
  output logic [15:0]          frame_count
);

  localparam int NBITS = 24 * LEDS;
  localparam int CW    = $clog2(NBITS + 1);
  localparam int IW    = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t             r_state, w_next_state;
  logic               r_sclk_s1, r_sclk_s2, r_sclk_prev;
  logic               r_sdat_s1, r_sdat_s2;
  logic [NBITS-1:0]   r_shift;
  logic [NBITS-1:0]   r_led;
  logic [CW-1:0]      r_bit_cnt;
  logic [IW-1:0]      r_idle_cnt;
  logic               r_ovf;
  logic               r_frame_valid, r_frame_error;
  logic [15:0]        r_frame_count;

  logic               w_edge, w_bit, w_timeout, w_good, w_full;
  logic               w_valid_d, w_error_d, w_busy;

  // Data and clock go through identical synchronisers so the sampled bit lines up with the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_sdat_s1   <= 1'b0;
      r_sdat_s2   <= 1'b0;
    end else begin
      r_sclk_s1   <= sclk_in;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_prev <= r_sclk_s2;
      r_sdat_s1   <= sdat_in;
      r_sdat_s2   <= r_sdat_s1;
    end
  end

  assign w_edge    = r_sclk_s2 & ~r_sclk_prev;
  assign w_bit     = r_sdat_s2;
  assign w_full    = (r_bit_cnt == CW'(NBITS));
  assign w_good    = w_full & ~r_ovf;
  // An edge arriving on the timeout cycle keeps the frame alive.
  assign w_timeout = (r_state == S_RECV) && !w_edge && (r_idle_cnt == IW'(IDLE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_edge)    w_next_state = S_RECV;
      S_RECV:  if (w_timeout) w_next_state = S_IDLE;
      default:                w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state == S_RECV);
    w_valid_d = w_timeout & w_good;
    w_error_d = w_timeout & ~w_good;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift       <= '0;
      r_led         <= '0;
      r_bit_cnt     <= '0;
      r_idle_cnt    <= '0;
      r_ovf         <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_valid <= w_valid_d;
      r_frame_error <= w_error_d;
      if (w_valid_d) begin
        r_led         <= r_shift;
        r_frame_count <= r_frame_count + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_shift    <= {r_shift[NBITS-2:0], w_bit};
            r_bit_cnt  <= CW'(1);
            r_idle_cnt <= '0;
            r_ovf      <= 1'b0;
          end
        end
        S_RECV: begin
          if (w_edge) begin
            r_idle_cnt <= '0;
            if (w_full) begin
              r_ovf <= 1'b1;
            end else begin
              r_shift   <= {r_shift[NBITS-2:0], w_bit};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (w_timeout) begin
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign led_rgb     = r_led;
  assign frame_valid = r_frame_valid;
  assign frame_error = r_frame_error;
  assign busy        = w_busy;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_led_stream_rx.sv
// Directed and randomised frames for led_stream_rx (LEDS=2, IDLE_CYCLES=20), checked
// against a segment-level model of how bit streams split into frames.
module tb_led_stream_rx;

  localparam int LEDS  = 2;
  localparam int IDLE  = 20;
  localparam int NBITS = 24 * LEDS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sclk_in = 1'b0;
  logic              sdat_in = 1'b0;
  logic [NBITS-1:0]  led_rgb;
  logic              frame_valid, frame_error, busy;
  logic [15:0]       frame_count;

  led_stream_rx #(.LEDS(LEDS), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .sdat_in(sdat_in),
    .led_rgb(led_rgb), .frame_valid(frame_valid), .frame_error(frame_error),
    .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rise = 0;
  int pulse_cyc = 0;
  int n_vs = 0;
  int n_es = 0;

  logic [NBITS-1:0] m_led = '0;
  int               m_count = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_valid) begin n_vs++; pulse_cyc = cyc; end
    if (frame_error) begin n_es++; pulse_cyc = cyc; end
    if (frame_valid && frame_error) begin
      n_errors++;
      $error("FAIL both_pulses: observed valid=1 error=1 expected never together");
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each bit: data changes with sclk falling, low phase, rise, 4-clk high phase.
  task automatic send_bits(input logic [63:0] data, input int n, input int sidx, input int slow);
    for (int i = n - 1; i >= 0; i--) begin
      sdat_in = data[i];
      repeat ((i == sidx) ? slow : 4) @(posedge clk);
      #1 sclk_in = 1'b1;
      last_rise = cyc;
      repeat (4) @(posedge clk);
      #1 sclk_in = 1'b0;
    end
  endtask

  // A rise-to-rise gap longer than IDLE ends the frame, so the stream splits into segments.
  task automatic model_segment(input logic [63:0] seg, input int len, inout int ev, inout int ee);
    if (len == NBITS) begin
      m_led = seg[NBITS-1:0];
      m_count = (m_count + 1) % 65536;
      ev++;
    end else if (len > 0) begin
      ee++;
    end
  endtask

  task automatic run_frame(input string tag, input logic [63:0] data, input int n,
                           input int sidx, input int slow);
    int v0, e0, ev, ee;
    logic [63:0] lo_mask;
    v0 = n_vs; e0 = n_es; ev = 0; ee = 0;
    send_bits(data, n, sidx, slow);
    repeat (40) @(posedge clk);
    #1;
    if (sidx >= 0 && slow + 4 > IDLE) begin
      lo_mask = (64'd1 << (sidx + 1)) - 64'd1;
      model_segment(data >> (sidx + 1), n - 1 - sidx, ev, ee);
      model_segment(data & lo_mask, sidx + 1, ev, ee);
    end else begin
      model_segment(data, n, ev, ee);
    end
    check({tag, "_valid_pulses"}, 64'(n_vs - v0), 64'(ev));
    check({tag, "_error_pulses"}, 64'(n_es - e0), 64'(ee));
    check({tag, "_led_rgb"}, 64'(led_rgb), 64'(m_led));
    check({tag, "_frame_count"}, 64'(frame_count), 64'(m_count));
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    if (ev + ee > 0) check({tag, "_latency"}, 64'(pulse_cyc - last_rise), 64'(IDLE + 3));
  endtask

  initial begin
    int v0, e0, r, n;
    logic [63:0] d;

    repeat (3) @(posedge clk);
    #1;
    check("reset_led", 64'(led_rgb), 64'd0);
    check("reset_count", 64'(frame_count), 64'd0);
    check("reset_pulses", 64'({frame_valid, frame_error}), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    run_frame("t1_good", 64'h0000_ff00_0000_ff00, 48, -1, 4);
    run_frame("t2_short", {$urandom, $urandom}, 47, -1, 4);
    run_frame("t3_long", {$urandom, $urandom}, 49, -1, 4);
    run_frame("t4_ones", 64'h0000_ffff_ffff_ffff, 48, -1, 4);
    repeat (30) @(posedge clk);
    run_frame("t4_zeros", 64'h0, 48, -1, 4);
    run_frame("gap_edge_wins", {$urandom, $urandom}, 48, 24, IDLE - 4);
    run_frame("gap_split", {$urandom, $urandom}, 48, 23, IDLE - 3);

    v0 = n_vs; e0 = n_es;
    #1;
    send_bits(64'h0000_0000_000a_bcde, 20, -1, 4);
    check("t5_busy_mid", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_led", 64'(led_rgb), 64'd0);
    check("t5_rst_count", 64'(frame_count), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    m_led = '0; m_count = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("t5_no_pulse", 64'((n_vs - v0) + (n_es - e0)), 64'd0);
    run_frame("t5_after", 64'h0000_0000_ff00_00ff, 48, -1, 4);

    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(0, 5);
      n = (r < 3) ? 48 : (r == 3) ? 47 : (r == 4) ? 49 : int'($urandom_range(1, 60));
      d = {$urandom, $urandom};
      run_frame("rand", d, n, -1, 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
